// File: rtl/m_store_wbuf.sv
// Store write buffer: encodes SW/SH/SB into word address, lane-replicated data and byte enables, then queues them to memory in order.
// Latency: a store pushed at edge N appears on the drain outputs in the following cycle; there is no push-to-drain bypass.
// Backpressure: o_ready drops while the buffer is full, and the head stays stable while wready is low. Macro STORE_ALIGN_CHK_EN enables misaligned-store rejection.
module m_store_wbuf #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [1:0]       i_seOp,
    input  logic [31:0]      i_Addr,
    input  logic [31:0]      i_WD,
    output logic             o_ready,
    output logic [31:0]      o_m_data_addr,
    output logic [31:0]      o_m_data_wdata,
    output logic [3:0]       o_m_data_byteen,
    output logic             o_m_data_wvalid,
    input  logic             i_m_data_wready,
    output logic             o_empty,
    output logic [PTR_W:0]   o_count,
    output logic             o_align_err
);

    localparam logic [1:0] SE_NONE = 2'b00;
    localparam logic [1:0] SE_SW   = 2'b01;
    localparam logic [1:0] SE_SH   = 2'b10;
    localparam logic [1:0] SE_SB   = 2'b11;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = (PTR_W)'(1);

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
    } entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    entry_t           mem [DEPTH];
    entry_t           enc;
    entry_t           head_ent;
    logic             req;
    logic             push;
    logic             pop;

    assign o_ready = (count != FULL_CNT);
    assign req     = i_valid && (i_seOp != SE_NONE) && o_ready;

`ifdef STORE_ALIGN_CHK_EN
    logic misalign;
    logic align_err;

    assign misalign = ((i_seOp == SE_SW) && (i_Addr[1:0] != 2'b00)) ||
                      ((i_seOp == SE_SH) && i_Addr[0]);
    assign push     = req && !misalign;

    // Pulses for the single cycle after the edge that rejected the store.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) align_err <= 1'b0;
        else          align_err <= req && misalign;
    end
    assign o_align_err = align_err;
`else
    assign push        = req;
    assign o_align_err = 1'b0;
`endif

    always_comb begin
        enc       = '0;
        enc.waddr = i_Addr[31:2];
        case (i_seOp)
            SE_SW: begin
                enc.byteen = 4'b1111;
                enc.wdata  = i_WD;
            end
            SE_SH: begin
                enc.byteen = i_Addr[1] ? 4'b1100 : 4'b0011;
                enc.wdata  = {2{i_WD[15:0]}};
            end
            SE_SB: begin
                enc.byteen = 4'b0001 << i_Addr[1:0];
                enc.wdata  = {4{i_WD[7:0]}};
            end
            default: enc = '0;
        endcase
    end

    // Payload storage carries no reset; the drain outputs are masked while empty.
    always_ff @(posedge i_clk) begin
        if (push) mem[tail] <= enc;
    end

    assign pop = o_m_data_wvalid && i_m_data_wready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= IDLE;
        end else begin
            state <= state_nxt;
            if (push) tail <= tail + PTR_ONE;
            if (pop)  head <= head + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (push) state_nxt = DRAIN;
            DRAIN:   if (pop && !push && (count == ONE_CNT)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_empty         = (state == IDLE);
    assign o_count         = count;
    assign o_m_data_wvalid = !o_empty;
    assign head_ent        = mem[head];

    always_comb begin
        o_m_data_addr   = '0;
        o_m_data_wdata  = '0;
        o_m_data_byteen = '0;
        if (!o_empty) begin
            o_m_data_addr   = {head_ent.waddr, 2'b00};
            o_m_data_wdata  = head_ent.wdata;
            o_m_data_byteen = head_ent.byteen;
        end
    end

endmodule

// File: doc/m_store_wbuf.md
Name: m_store_wbuf

Overview:
- Store-side counterpart of the M-stage load data extender: encodes SW/SH/SB stores into a word-aligned address, replicated write data and 4-bit byte enables.
- Queues the encoded stores in a small FIFO write buffer and drains them to data memory with a valid/ready handshake.
- Sits between the M-stage pipeline register and the data-memory write port. The pipeline stalls on o_ready low.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, >= 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- i_clk, input, 1, clock; all state changes on rising edge.
- i_rst_n, input, 1, reset.
- i_valid, input, 1, store request valid this cycle.
- i_seOp, input, 2, store op: 2'b00 SE_NONE, 2'b01 SE_SW, 2'b10 SE_SH, 2'b11 SE_SB.
- i_Addr, input, 32, byte address of the store.
- i_WD, input, 32, register data to store; the low bytes are used for SH/SB.
- o_ready, output, 1, buffer can accept a request this cycle.
- o_m_data_addr, output, 32, head entry word address, with [1:0] = 2'b00.
- o_m_data_wdata, output, 32, head entry write data.
- o_m_data_byteen, output, 4, head entry byte enables; bit k enables bits [8k+7:8k].
- o_m_data_wvalid, output, 1, head entry valid.
- i_m_data_wready, input, 1, memory accepts the head entry this cycle.
- o_empty, output, 1, no entries buffered.
- o_count, output, PTR_W+1, number of buffered entries.
- o_align_err, output, 1, misaligned store rejected; see Optional Feature.

Interface decisions:
- One clock; reset is asynchronous and active-low.
- i_rst_n is asserted asynchronously and released synchronously to i_clk by the top level.

Behaviour:
- Reset state: head pointer, tail pointer and count are 0. o_empty=1, o_ready=1. o_m_data_wvalid=0, o_m_data_addr=0, o_m_data_wdata=0, o_m_data_byteen=0, o_align_err=0.
- Reset mid-drain: all buffered entries are discarded. The in-flight head write is dropped and wvalid falls immediately on reset assertion.
- Push occurs when i_valid && i_seOp!=SE_NONE && o_ready, and the request is not rejected by the alignment check.
- i_valid with SE_NONE: no push, no error.
- Encoding at push (a = i_Addr[1:0]):
  - SW: byteen=4'b1111, wdata=i_WD.
  - SH: byteen=4'b0011<<(2*a[1]), wdata={2{i_WD[15:0]}}.
  - SB: byteen=4'b0001<<a, wdata={4{i_WD[7:0]}}.
  - addr={i_Addr[31:2],2'b00} for all ops.
- Storage: entries are stored in a DEPTH-entry array written at the tail pointer. Tail increments modulo DEPTH on push.
- Drain outputs: o_m_data_wvalid = !o_empty. The addr/wdata/byteen outputs show the head entry, and are forced to 0 when empty.
- Pop occurs when o_m_data_wvalid && i_m_data_wready. Head increments modulo DEPTH.
- Head outputs stay stable while wvalid=1 and wready=0.
- Latency: a store pushed at edge N appears on the drain outputs in the cycle after edge N. There is no combinational bypass from the push inputs to the drain outputs.
- Occupancy rules:
  - o_ready = (o_count != DEPTH), computed from registered count only. A pop in the same cycle does not free a slot for a push in that cycle.
  - Push and pop in the same cycle (not full, not empty): count unchanged, both pointers advance.
  - Push into empty with wready=1: the entry is not popped that cycle, because wvalid is still 0.
  - Full: pushes are ignored, and the pipeline must hold the request.
  - Empty: wready is ignored.
- Drain FSM:
  - States: IDLE (count==0), DRAIN (count>0).
  - IDLE->DRAIN on push.
  - DRAIN->IDLE on a pop with no push when count==1.
  - o_empty is equivalent to state IDLE.
- Ordering: strict FIFO; the memory sees stores in program order.

Optional Feature:
- Macro: STORE_ALIGN_CHK_EN.
- Defined:
  - A request is misaligned when it is SW with i_Addr[1:0]!=0, or SH with i_Addr[0]!=0.
  - A misaligned request with i_valid && o_ready is not pushed.
  - o_align_err is registered: it is 1 for exactly one cycle after the rejecting edge, otherwise 0.
  - SB is never misaligned.
- Undefined:
  - o_align_err is tied to 0.
  - Misaligned requests are pushed. SW ignores a; SH ignores a[0].

Test Plan:
1. Reset, then push SB addr 0x1003 data 0x000000A5 with wready=0 -> next cycle wvalid=1, addr=0x1000, wdata=0xA5A5A5A5, byteen=4'b1000, count=1.
2. Push SH addr 0x2002 data 0x0000BEEF, then SW addr 0x2004 data 0x12345678, wready=1 throughout -> memory sees {0x2000, 0xBEEFBEEF, 4'b1100} then {0x2004, 0x12345678, 4'b1111}, in that order.
3. Push 4 stores with wready=0 -> o_ready=0, count=4. A fifth push is ignored. Raise wready and push on the same cycle -> the first pop completes, the push is rejected, and o_ready=1 next cycle.
4. Steady stream with push and pop every cycle at count=2 -> count stays 2 and the entries drain in order.
5. Assert i_rst_n=0 mid-drain at count=3 -> wvalid=0 and count=0 immediately, with no further writes after release.
6. With STORE_ALIGN_CHK_EN: SW addr 0x3001 -> no push, count unchanged, o_align_err=1 for one cycle. Without it: wvalid next cycle with addr=0x3000, byteen=4'b1111.
